// File: rtl/cmp_pkg.sv
// Shared definitions for the successive-approximation search controller:
// state encodings and the comparator flag-validity helper.
package cmp_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam int CNT_W = 4;

  // A well-behaved comparator raises exactly one of gre/les/eq.
  function automatic logic onehot3(input logic a, input logic b, input logic c);
    return (a & ~b & ~c) | (~a & b & ~c) | (~a & ~b & c);
  endfunction

endpackage

// File: rtl/settle_counter.sv
// Settle-wait counter: loads the wait length, counts down, and flags the last
// settle cycle so the controller can move on to sampling.
module settle_counter
  import cmp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

  assign tc = (cnt_reg == CNT_W'(1));

endmodule

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller: drives trial codes MSB-first into
// an external comparator and reports the exact match or largest code <= target.
module sar_search_ctrl
  import cmp_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             gre,
  input  logic             les,
  input  logic             eq,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             found,
  output logic             err
);

  localparam int               IDX_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] TRIAL_INIT = WIDTH'(1) << (WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_INIT   = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE);
  localparam state_t           FIRST_ST   = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] trial_reg, trial_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             found_reg, found_next;
  logic             err_reg, err_next;
  logic             cnt_load, cnt_dec, cnt_tc;
  logic [WIDTH-1:0] bit_mask;
  logic [WIDTH-1:0] trial_upd;

  settle_counter u_settle (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (SETTLE_CNT),
    .dec      (cnt_dec),
    .tc       (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      trial_reg  <= '0;
      idx_reg    <= '0;
      result_reg <= '0;
      found_reg  <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      trial_reg  <= trial_next;
      idx_reg    <= idx_next;
      result_reg <= result_next;
      found_reg  <= found_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    trial_next  = trial_reg;
    idx_next    = idx_reg;
    result_next = result_reg;
    found_next  = found_reg;
    err_next    = err_reg;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    bit_mask    = WIDTH'(1) << idx_reg;
    // "trial too high" drops the bit under test; "too low" keeps it.
    trial_upd   = gre ? (trial_reg & ~bit_mask) : trial_reg;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          trial_next = TRIAL_INIT;
          idx_next   = IDX_INIT;
          cnt_load   = 1'b1;
          found_next = 1'b0;
          err_next   = 1'b0;
          state_next = FIRST_ST;
        end
      end
      S_SETTLE: begin
        cnt_dec = 1'b1;
        if (cnt_tc) state_next = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (!onehot3(gre, les, eq)) begin
          err_next    = 1'b1;
          result_next = trial_reg;
          state_next  = S_DONE;
        end else if (eq) begin
          found_next  = 1'b1;
          result_next = trial_reg;
          state_next  = S_DONE;
        end else if (idx_reg == '0) begin
          trial_next  = trial_upd;
          result_next = trial_upd;
          state_next  = S_DONE;
        end else begin
          trial_next = trial_upd | (bit_mask >> 1);
          idx_next   = idx_reg - IDX_W'(1);
          cnt_load   = 1'b1;
          state_next = FIRST_ST;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign trial  = trial_reg;
  assign busy   = (state_reg == S_SETTLE) || (state_reg == S_SAMPLE);
  assign done   = (state_reg == S_DONE);
  assign result = result_reg;
  assign found  = found_reg;
  assign err    = err_reg;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Bench for sar_search_ctrl: two instances (no settle, settle of 2) share the
// stimulus; a timeline model built from a plain binary search is checked every cycle.
module tb_sar_search_ctrl;

  typedef struct packed {
    logic [3:0] trial;
    logic       busy;
    logic       done;
    logic [3:0] result;
    logic       found;
    logic       err;
  } snap_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] target = 4'd0;
  int         mode = 0;

  logic [3:0] trial0, result0, trial2, result2;
  logic       busy0, done0, found0, err0, gre0, les0, eq0;
  logic       busy2, done2, found2, err2, gre2, les2, eq2;

  int n_checks = 0;
  int n_errors = 0;

  snap_t tl [2][0:63];
  int    tl_len [2];
  int    tl_pos [2];
  snap_t cur [2];

  int         lat [2];
  logic [3:0] tr0_log [0:63];
  logic [3:0] tr2_log [0:63];

  always #5 clk = ~clk;

  // Comparator: mode 0 honest, mode 1 gre=les=1, mode 2 all flags low.
  function automatic logic [2:0] cmp_flags(input logic [3:0] t, input logic [3:0] tg, input int md);
    if (md == 1) return 3'b110;
    if (md == 2) return 3'b000;
    return {t > tg, t < tg, t == tg};
  endfunction

  assign {gre0, les0, eq0} = cmp_flags(trial0, target, mode);
  assign {gre2, les2, eq2} = cmp_flags(trial2, target, mode);

  sar_search_ctrl #(.WIDTH(4), .SETTLE(0)) u0 (
    .clk(clk), .rst(rst), .start(start), .gre(gre0), .les(les0), .eq(eq0),
    .trial(trial0), .busy(busy0), .done(done0), .result(result0), .found(found0), .err(err0)
  );

  sar_search_ctrl #(.WIDTH(4), .SETTLE(2)) u2 (
    .clk(clk), .rst(rst), .start(start), .gre(gre2), .les(les2), .eq(eq2),
    .trial(trial2), .busy(busy2), .done(done2), .result(result2), .found(found2), .err(err2)
  );

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Whole-search timeline: each trial is visible for settle+1 cycles, then one done cycle.
  task automatic build(input int d);
    snap_t      s;
    logic [2:0] f;
    logic [3:0] t;
    int         sw;
    sw = (d == 0) ? 0 : 2;
    t = 4'd8;
    s = '0;
    s.busy = 1'b1;
    s.result = cur[d].result;
    tl_len[d] = 0;
    for (int b = 3; b >= 0; b--) begin
      for (int k = 0; k <= sw; k++) begin
        s.trial = t;
        tl[d][tl_len[d]] = s;
        tl_len[d]++;
      end
      f = cmp_flags(t, target, mode);
      if (f != 3'b100 && f != 3'b010 && f != 3'b001) begin
        s.err = 1'b1;
        break;
      end
      if (f[0]) begin
        s.found = 1'b1;
        break;
      end
      if (f[2]) t = t - 4'(1 << b);
      if (b == 0) break;
      t = t + 4'(1 << (b - 1));
    end
    s.trial = t;
    s.busy = 1'b0;
    s.done = 1'b1;
    s.result = t;
    tl[d][tl_len[d]] = s;
    tl_len[d]++;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      cur[d] = '0;
      tl_len[d] = 0;
      tl_pos[d] = 0;
    end
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst) begin
          tl_len[d] = 0;
          tl_pos[d] = 0;
          cur[d] = '0;
        end else if (tl_pos[d] < tl_len[d]) begin
          cur[d] = tl[d][tl_pos[d]];
          tl_pos[d]++;
        end else if (start && !cur[d].done) begin
          build(d);
          cur[d] = tl[d][0];
          tl_pos[d] = 1;
        end else begin
          cur[d].done = 1'b0;
          cur[d].busy = 1'b0;
        end
      end
    end
  end

  initial begin
    snap_t a0, a2;
    forever begin
      @(negedge clk);
      a0 = {trial0, busy0, done0, result0, found0, err0};
      a2 = {trial2, busy2, done2, result2, found2, err2};
      check("model_u0", int'(a0), int'(cur[0]));
      check("model_u2", int'(a2), int'(cur[1]));
    end
  end

  task automatic run_search(input logic [3:0] tgt, input int md);
    @(negedge clk);
    target = tgt;
    mode = md;
    start = 1'b1;
    lat[0] = 0;
    lat[1] = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start = 1'b0;
      tr0_log[n] = trial0;
      tr2_log[n] = trial2;
      if (done0 && lat[0] == 0) lat[0] = n;
      if (done2 && lat[1] == 0) lat[1] = n;
      if (lat[0] != 0 && lat[1] != 0) break;
    end
    check("done_seen_u0", int'(lat[0] > 0), 1);
    check("done_seen_u2", int'(lat[1] > 0), 1);
    $display("search target=%0d mode=%0d lat0=%0d lat2=%0d res0=%0d found0=%0d err0=%0d res2=%0d found2=%0d err2=%0d",
             tgt, md, lat[0], lat[1], result0, found0, err0, result2, found2, err2);
  endtask

  initial begin
    int nd0, nd2;
    repeat (3) @(negedge clk);
    check("rst_trial", int'(trial0), 0);
    check("rst_busy", int'(busy0), 0);
    check("rst_done", int'(done2), 0);
    rst = 1'b0;

    run_search(4'd5, 0);
    check("t5_tr1", int'(tr0_log[1]), 8);
    check("t5_tr2", int'(tr0_log[2]), 4);
    check("t5_tr3", int'(tr0_log[3]), 6);
    check("t5_tr4", int'(tr0_log[4]), 5);
    check("t5_lat0", lat[0], 5);
    check("t5_lat2", lat[1], 13);
    check("t5_res", int'(result0), 5);
    check("t5_found", int'(found0), 1);
    check("t5_err", int'(err0), 0);

    run_search(4'd15, 0);
    check("t15_tr4", int'(tr0_log[4]), 15);
    check("t15_res", int'(result0), 15);
    check("t15_found", int'(found0), 1);

    run_search(4'd0, 0);
    check("t0_tr2", int'(tr0_log[2]), 4);
    check("t0_tr3", int'(tr0_log[3]), 2);
    check("t0_tr4", int'(tr0_log[4]), 1);
    check("t0_res", int'(result0), 0);
    check("t0_found", int'(found0), 0);

    run_search(4'd9, 0);
    check("t9_hold_a", int'(tr2_log[3]), 8);
    check("t9_hold_b", int'(tr2_log[4]), 12);
    check("t9_tr_c", int'(tr2_log[7]), 10);
    check("t9_tr_d", int'(tr2_log[12]), 9);
    check("t9_lat2", lat[1], 13);
    check("t9_res2", int'(result2), 9);
    check("t9_found2", int'(found2), 1);

    run_search(4'd7, 1);
    check("e1_err", int'(err0), 1);
    check("e1_res", int'(result0), 8);
    check("e1_found", int'(found0), 0);
    check("e1_lat0", lat[0], 2);
    check("e1_lat2", lat[1], 4);

    run_search(4'd7, 2);
    check("e2_err", int'(err2), 1);
    check("e2_res", int'(result2), 8);

    // start held high for 30 cycles: back-to-back searches, one done each.
    @(negedge clk);
    target = 4'd5;
    mode = 0;
    start = 1'b1;
    nd0 = 0;
    nd2 = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (done0) nd0++;
      if (done2) nd2++;
    end
    start = 1'b0;
    check("hold_dones_u0", nd0, 5);
    check("hold_dones_u2", nd2, 2);
    $display("hold start: dones u0=%0d u2=%0d", nd0, nd2);
    repeat (20) @(negedge clk);

    // Reset during u0's second sample aborts both searches.
    target = 4'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_trial", int'(trial0), 0);
    check("abort_busy", int'(busy0), 0);
    check("abort_done", int'(done0), 0);
    check("abort_res", int'(result0), 0);
    check("abort_busy2", int'(busy2), 0);
    $display("reset mid-search: trial0=%0d busy0=%0d result0=%0d", trial0, busy0, result0);
    rst = 1'b0;

    run_search(4'd3, 0);
    check("post_rst_res0", int'(result0), 3);
    check("post_rst_found0", int'(found0), 1);
    check("post_rst_res2", int'(result2), 3);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
